mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the multicycle accumulator CPU controller. It services the controller's memRead/memWrite strobes against a unified instruction/data byte store, inserting a configurable number of wait states. It returns read data plus a one-cycle memReady completion pulse, and flags illegal simultaneous read/write requests. It sits between the datapath address/data muxes and the storage array.

Parameters:
DATA_W, 8, width of one memory word (byte)
ADDR_W, 12, address width; depth = 2**ADDR_W words
WAIT_CYCLES, 2, wait states between request capture and response (0 allowed)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
memRead  input  1  read request level from controller
memWrite  input  1  write request level from controller
memAddress  input  ADDR_W  request address
memWriteData  input  DATA_W  write data
memReadData  output  DATA_W  registered read data, held until next read completes
memReady  output  1  one-cycle pulse: access complete
memBusy  output  1  high while a request is captured and not yet completed
memError  output  1  one-cycle pulse: memRead and memWrite both high at capture

Behaviour:
- Reset (rst low, asynchronous): state IDLE, wait counter 0, memReadData 0, memReady 0, memBusy 0, memError 0, latched address/data/op cleared. Storage contents are NOT cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a rising edge with exactly one of memRead/memWrite high, latch op, memAddress and memWriteData, and load the counter with WAIT_CYCLES. Next state: WAIT if WAIT_CYCLES>0, else RESP.
- IDLE with both strobes high: no capture; memError=1 for the next cycle; stay IDLE.
- IDLE with neither strobe high: stay IDLE.
- WAIT: counter decrements each edge; go to RESP on the edge where the counter reaches 1. memBusy=1. Input strobe, address and data changes are ignored.
- RESP: memBusy=1 and memReady=1 for exactly this cycle.
  - Read: memReadData is updated from store[latched address] on the edge entering RESP.
  - Write: store[latched address] is written with latched data on the edge leaving RESP.
  - Next state is always IDLE.
- Latency: request captured at edge E; memReady is high during the cycle after edge E+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after capture.
- Back-to-back requests: a strobe still high in the IDLE cycle after RESP is a new request. The controller drops the strobe, or accepts repetition (reads are idempotent; a repeated write rewrites the same value).
- Read-after-write to the same address: a read captured in the IDLE following a write RESP returns the new data.
- memReadData is held unchanged across writes, errors and idle cycles.
- Addresses wrap naturally within ADDR_W; there is no out-of-range condition.
- Reset mid-operation (WAIT or RESP): the access is aborted, a pending write is not committed, and no memReady is issued.
- The counter is sized to hold WAIT_CYCLES; with WAIT_CYCLES=0 the counter is unused and the transition is IDLE->RESP.

Decomposition:
- Shared package mem_pkg: state encoding constants (IDLE, WAIT, RESP), default DATA_W/ADDR_W, and the op encoding (OP_READ, OP_WRITE).
- One sub-module, mem_array: single-port storage of 2**ADDR_W x DATA_W with synchronous write enable and registered read. mem_responder owns the FSM, counter, latches and handshake outputs.

Test Plan:
- Reset then memWrite=1, addr=0x010, data=0xA5 with WAIT_CYCLES=2 -> memBusy high for 3 cycles, memReady pulse in cycle 3 after capture, memError 0.
- Then memRead=1, addr=0x010 -> memReadData=0xA5 and memReady pulse 3 cycles after capture; memReadData still 0xA5 ten idle cycles later.
- memRead=1 and memWrite=1 together at addr=0x020 data=0x3C -> memError single pulse, no memReady, later read of 0x020 returns prior value (0x00 if never written).
- Change memAddress/memWriteData and toggle strobes during WAIT -> captured access completes with the original values; a write to 0xFFF followed by a read of 0xFFF returns the written byte.
- Assert rst low during WAIT of a write 0x5A to 0x030 -> outputs immediately 0, no memReady; read of 0x030 after reset returns the old value.
- WAIT_CYCLES=0 build: memRead held high for 4 cycles at 0x010 -> alternating RESP/IDLE, memReady every second cycle, data 0xA5 each time.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: state and op encodings,
// default widths and the wait-counter sizing helper.
package mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Counter must hold WAIT_CYCLES itself; keep at least one bit when it is 0.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Controller <-> memory responder handshake: strobes, address/data and
// the completion/busy/error status returned by the responder.
interface mem_responder_if #(
  parameter int DATA_W = mem_pkg::DEF_DATA_W,
  parameter int ADDR_W = mem_pkg::DEF_ADDR_W
);
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;
  logic              memReady;
  logic              memBusy;
  logic              memError;

  modport master (
    output memRead, memWrite, memAddress, memWriteData,
    input  memReadData, memReady, memBusy, memError
  );

  modport slave (
    input  memRead, memWrite, memAddress, memWriteData,
    output memReadData, memReady, memBusy, memError
  );
endinterface

// File: rtl/mem_array.sv
// Single-port byte store with synchronous write and a registered,
// read-enabled output that holds its value between reads.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] store [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_reg;

  // Storage contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      store[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= store[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one read or write, inserts WAIT_CYCLES
// wait states, then completes with a one-cycle memReady pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  op_t               op_reg, op_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              error_reg, error_next;

  op_t               req_op;
  logic              req_one;
  logic              req_both;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign req_op   = bus.memWrite ? OP_WRITE : OP_READ;
  assign req_one  = bus.memRead ^ bus.memWrite;
  assign req_both = bus.memRead & bus.memWrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_READ;
      addr_reg  <= '0;
      wdata_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    error_next = 1'b0;
    mem_re     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_both) begin
          error_next = 1'b1;
        end else if (req_one) begin
          op_next    = req_op;
          addr_next  = bus.memAddress;
          wdata_next = bus.memWriteData;
          cnt_next   = CNT_LOAD;
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
          end else begin
            state_next = RESP;
            // Zero wait states: the array reads straight from the bus address.
            mem_re     = (req_op == OP_READ);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = RESP;
          mem_re     = (op_reg == OP_READ);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write commits on the edge leaving RESP; a reset during RESP drops
  // state_reg to IDLE immediately, so an aborted write never lands.
  assign mem_we   = (state_reg == RESP) && (op_reg == OP_WRITE);
  assign mem_addr = (state_reg == IDLE) ? bus.memAddress : addr_reg;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  assign bus.memReadData = mem_rdata;
  assign bus.memReady    = (state_reg == RESP);
  assign bus.memBusy     = (state_reg != IDLE);
  assign bus.memError    = error_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: a WAIT_CYCLES=2 instance
// for the main scenarios and a WAIT_CYCLES=0 instance for back-to-back reads.
module tb_mem_responder;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int W  = 2;
  localparam int W0 = 0;

  typedef struct {
    int           kind;   // 0 read, 1 write, 2 error
    logic [7:0]   data;
    logic [11:0]  addr;
    int           due;    // cycle number in which the response is visible
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus  ();
  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       q[$];
  exp_t       q0[$];
  logic [7:0] model  [4096];
  logic [7:0] model0 [4096];
  logic [11:0] waddrs[$];
  logic [7:0] hold  = '0;
  logic [7:0] hold0 = '0;
  int         free0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Main-instance monitor: busy window, response kind/timing, held read data.
  always @(negedge clk) begin : mon
    exp_t e;
    logic busy_exp;
    if (!rst) begin
      hold = '0;
    end else begin
      if (q.size() > 0 && cyc > q[0].due) begin
        e = q.pop_front();
        check("missed_resp", 32'(cyc), 32'(e.due));
      end
      busy_exp = (q.size() > 0) && (q[0].kind != 2) && (cyc >= q[0].due - W);
      check("busy", 32'(bus.memBusy), 32'(busy_exp));
      if (bus.memReady || bus.memError) begin
        if (q.size() == 0) begin
          check("spurious_resp", {30'd0, bus.memReady, bus.memError}, 32'd0);
        end else begin
          e = q.pop_front();
          check("resp_kind", {30'd0, bus.memReady, bus.memError},
                (e.kind == 2) ? 32'd1 : 32'd2);
          check("resp_cycle", 32'(cyc), 32'(e.due));
          if (e.kind == 0) hold = e.data;
          $display("txn dut=W2 kind=%0d addr=%03h data=%02h rdata=%02h cyc=%0d",
                   e.kind, e.addr, e.data, bus.memReadData, cyc);
        end
      end
      check("read_data", 32'(bus.memReadData), 32'(hold));
    end
  end

  // Zero-wait-state instance monitor.
  always @(negedge clk) begin : mon0
    exp_t e;
    logic busy_exp;
    if (!rst) begin
      hold0 = '0;
    end else begin
      if (q0.size() > 0 && cyc > q0[0].due) begin
        e = q0.pop_front();
        check("w0_missed_resp", 32'(cyc), 32'(e.due));
      end
      busy_exp = (q0.size() > 0) && (q0[0].kind != 2) && (cyc >= q0[0].due - W0);
      check("w0_busy", 32'(bus0.memBusy), 32'(busy_exp));
      if (bus0.memReady || bus0.memError) begin
        if (q0.size() == 0) begin
          check("w0_spurious_resp", {30'd0, bus0.memReady, bus0.memError}, 32'd0);
        end else begin
          e = q0.pop_front();
          check("w0_resp_kind", {30'd0, bus0.memReady, bus0.memError},
                (e.kind == 2) ? 32'd1 : 32'd2);
          check("w0_resp_cycle", 32'(cyc), 32'(e.due));
          if (e.kind == 0) hold0 = e.data;
          $display("txn dut=W0 kind=%0d addr=%03h data=%02h rdata=%02h cyc=%0d",
                   e.kind, e.addr, e.data, bus0.memReadData, cyc);
        end
      end
      check("w0_read_data", 32'(bus0.memReadData), 32'(hold0));
    end
  end

  task automatic garbage();
    bus.memRead      = 1'($urandom_range(0, 1));
    bus.memWrite     = 1'($urandom_range(0, 1));
    bus.memAddress   = 12'($urandom);
    bus.memWriteData = 8'($urandom);
  endtask

  // Called at a negedge; scrambles the bus while the responder is busy.
  task automatic wait_idle();
    int guard = 0;
    while (bus.memBusy && guard < 50) begin
      garbage();
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("busy_timeout", 32'(guard), 32'd0);
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [11:0] a, input logic [7:0] d);
    exp_t e;
    wait_idle();
    bus.memRead      = rd;
    bus.memWrite     = wr;
    bus.memAddress   = a;
    bus.memWriteData = d;
    e.addr = a;
    e.data = d;
    e.due  = cyc + 1;
    if (rd && wr) begin
      e.kind = 2;
    end else if (rd) begin
      e.kind = 0;
      e.data = model[a];
      e.due += W;
    end else begin
      e.kind = 1;
      model[a] = d;
      e.due += W;
    end
    if (rd || wr) q.push_back(e);
    @(negedge clk);
    if (rd && wr) begin
      bus.memRead  = 1'b0;
      bus.memWrite = 1'b0;
    end else begin
      garbage();
    end
  endtask

  task automatic idle(input int n);
    wait_idle();
    repeat (n) @(negedge clk);
  endtask

  // Holds the strobe for hold_n cycles; every edge that finds the responder
  // free starts a new access, completing WAIT_CYCLES cycles later.
  task automatic issue0(input bit rd, input bit wr, input logic [11:0] a,
                        input logic [7:0] d, input int hold_n);
    exp_t e;
    for (int h = 0; h < hold_n; h++) begin
      bus0.memRead      = rd;
      bus0.memWrite     = wr;
      bus0.memAddress   = a;
      bus0.memWriteData = d;
      if (cyc + 1 >= free0) begin
        e.addr = a;
        e.kind = wr ? 1 : 0;
        e.data = wr ? d : model0[a];
        e.due  = cyc + 1 + W0;
        if (wr) model0[a] = d;
        free0 = cyc + 1 + W0 + 2;
        q0.push_back(e);
      end
      @(negedge clk);
    end
    bus0.memRead  = 1'b0;
    bus0.memWrite = 1'b0;
  endtask

  initial begin
    logic [7:0]  old;
    logic [11:0] a;
    int          sel;
    bus.memRead = 1'b0;  bus.memWrite = 1'b0;  bus.memAddress = '0;  bus.memWriteData = '0;
    bus0.memRead = 1'b0; bus0.memWrite = 1'b0; bus0.memAddress = '0; bus0.memWriteData = '0;

    repeat (3) @(negedge clk);
    check("rst_busy",  32'(bus.memBusy),     32'd0);
    check("rst_ready", 32'(bus.memReady),    32'd0);
    check("rst_error", 32'(bus.memError),    32'd0);
    check("rst_rdata", 32'(bus.memReadData), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);

    issue(0, 1, 12'h010, 8'hA5);
    issue(1, 0, 12'h010, 8'h00);
    idle(10);

    issue(0, 1, 12'h020, 8'h77);
    issue(1, 1, 12'h020, 8'h3C);
    idle(2);
    issue(1, 0, 12'h020, 8'h00);

    issue(0, 1, 12'hFFF, 8'hC3);
    issue(1, 0, 12'hFFF, 8'h00);

    issue(0, 1, 12'h030, 8'h11);
    old = 8'h11;
    issue(0, 1, 12'h030, 8'h5A);
    #2 rst = 1'b0;
    #1;
    check("abort_busy",  32'(bus.memBusy),     32'd0);
    check("abort_ready", 32'(bus.memReady),    32'd0);
    check("abort_error", 32'(bus.memError),    32'd0);
    check("abort_rdata", 32'(bus.memReadData), 32'd0);
    q.delete();
    q0.delete();
    model[12'h030] = old;
    bus.memRead = 1'b0;
    bus.memWrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    issue(1, 0, 12'h030, 8'h00);

    waddrs = '{12'h010, 12'h020, 12'h030, 12'hFFF};
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        a = 12'($urandom);
        issue(0, 1, a, 8'($urandom));
        waddrs.push_back(a);
      end else if (sel < 9) begin
        a = waddrs[$urandom_range(0, waddrs.size() - 1)];
        issue(1, 0, a, 8'($urandom));
      end else begin
        issue(1, 1, 12'($urandom), 8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(4);

    @(negedge clk);
    issue0(0, 1, 12'h010, 8'hA5, 1);
    repeat (2) @(negedge clk);
    issue0(1, 0, 12'h010, 8'h00, 4);
    repeat (4) @(negedge clk);
    issue0(0, 1, 12'h7FF, 8'h42, 1);
    issue0(1, 0, 12'h7FF, 8'h00, 3);
    repeat (4) @(negedge clk);

    check("queue_drained", 32'(q.size() + q0.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
